// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ctrl
// Brief   : Pointer, occupancy and byte-offset controller for the SCSI DMA
//           longword FIFO, with sticky overrun/underrun and synchronous flush.
// Revision: 1.0  initial release
// ============================================================================
module fifo_ctrl #(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          CPUCLK,
    input  logic          RESET_,
    input  logic          INCNI,
    input  logic          INCNO,
    input  logic          INCFIFO,
    input  logic          DECFIFO,
    input  logic          INCBO,
    input  logic          FLUSH,
    output logic [PW-1:0] WRPTR,
    output logic [PW-1:0] RDPTR,
    output logic [CW-1:0] LWCOUNT,
    output logic [1:0]    BO,
    output logic [3:0]    BLANE,
    output logic          BOEQ3,
    output logic          FIFOFULL,
    output logic          FIFOEMPTY,
    output logic          OVERRUN,
    output logic          UNDERRUN
);

    localparam logic [CW-1:0] c_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] c_EMPTY = '0;
    localparam logic [CW-1:0] c_ONE   = CW'(1);
    localparam logic [PW-1:0] c_PONE  = PW'(1);

    logic [PW-1:0] r_wrptr;
    logic [PW-1:0] r_rdptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_bo;
    logic          r_overrun;
    logic          r_underrun;

    logic          w_full;
    logic          w_empty;
    logic          w_add_only;
    logic          w_rem_only;

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == c_EMPTY);
    // Simultaneous add/remove is a legal pass-through at any occupancy.
    assign w_add_only = INCFIFO & ~DECFIFO;
    assign w_rem_only = DECFIFO & ~INCFIFO;

    always_ff @(posedge CPUCLK or negedge RESET_) begin
        if (!RESET_) begin
            r_wrptr    <= '0;
            r_rdptr    <= '0;
            r_count    <= '0;
            r_bo       <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else if (FLUSH) begin
            r_wrptr    <= '0;
            r_rdptr    <= '0;
            r_count    <= '0;
            r_bo       <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (INCNI) r_wrptr <= r_wrptr + c_PONE;
            if (INCNO) r_rdptr <= r_rdptr + c_PONE;
            if (INCBO) r_bo    <= r_bo + 2'd1;

            if (w_add_only) begin
                if (w_full) r_overrun <= 1'b1;
                else        r_count   <= r_count + c_ONE;
            end else if (w_rem_only) begin
                if (w_empty) r_underrun <= 1'b1;
                else         r_count    <= r_count - c_ONE;
            end
        end
    end

    assign WRPTR     = r_wrptr;
    assign RDPTR     = r_rdptr;
    assign LWCOUNT   = r_count;
    assign BO        = r_bo;
    // Big-endian lane select: offset 0 addresses D31:24.
    assign BLANE     = 4'b1000 >> r_bo;
    assign BOEQ3     = (r_bo == 2'd3);
    assign FIFOFULL  = w_full;
    assign FIFOEMPTY = w_empty;
    assign OVERRUN   = r_overrun;
    assign UNDERRUN  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_ctrl
// Brief   : Scoreboard bench for fifo_ctrl (DEPTH = 8).
// Revision: 1.0  initial release
// ============================================================================
module tb_fifo_ctrl;

    typedef struct packed {
        logic [2:0] wr;
        logic [2:0] rd;
        logic [3:0] cnt;
        logic [1:0] bo;
        logic [3:0] blane;
        logic       boeq3;
        logic       full;
        logic       empty;
        logic       ovr;
        logic       und;
    } st_t;

    // strobe vector order: {INCNI, INCNO, INCFIFO, DECFIFO, INCBO, FLUSH}
    localparam logic [5:0] S_NI = 6'b100000;
    localparam logic [5:0] S_NO = 6'b010000;
    localparam logic [5:0] S_IN = 6'b001000;
    localparam logic [5:0] S_DE = 6'b000100;
    localparam logic [5:0] S_BO = 6'b000010;
    localparam logic [5:0] S_FL = 6'b000001;
    localparam logic [5:0] S_ID = 6'b000000;

    logic       CPUCLK = 1'b0;
    logic       RESET_ = 1'b0;
    logic       INCNI = 1'b0, INCNO = 1'b0, INCFIFO = 1'b0;
    logic       DECFIFO = 1'b0, INCBO = 1'b0, FLUSH = 1'b0;
    logic [2:0] WRPTR, RDPTR;
    logic [3:0] LWCOUNT;
    logic [1:0] BO;
    logic [3:0] BLANE;
    logic       BOEQ3, FIFOFULL, FIFOEMPTY, OVERRUN, UNDERRUN;

    int checks   = 0;
    int failures = 0;

    st_t exp_q[$];

    int m_wr, m_rd, m_cnt, m_bo;
    bit m_ovr, m_und;

    fifo_ctrl #(.DEPTH(8)) dut (
        .CPUCLK   (CPUCLK),
        .RESET_   (RESET_),
        .INCNI    (INCNI),
        .INCNO    (INCNO),
        .INCFIFO  (INCFIFO),
        .DECFIFO  (DECFIFO),
        .INCBO    (INCBO),
        .FLUSH    (FLUSH),
        .WRPTR    (WRPTR),
        .RDPTR    (RDPTR),
        .LWCOUNT  (LWCOUNT),
        .BO       (BO),
        .BLANE    (BLANE),
        .BOEQ3    (BOEQ3),
        .FIFOFULL (FIFOFULL),
        .FIFOEMPTY(FIFOEMPTY),
        .OVERRUN  (OVERRUN),
        .UNDERRUN (UNDERRUN)
    );

    always #5 CPUCLK = ~CPUCLK;

    task automatic model_clear();
        m_wr = 0; m_rd = 0; m_cnt = 0; m_bo = 0; m_ovr = 0; m_und = 0;
    endtask

    task automatic model_step(input logic [5:0] s);
        if (s[0]) begin
            model_clear();
        end else begin
            if (s[5]) m_wr = (m_wr + 1) % 8;
            if (s[4]) m_rd = (m_rd + 1) % 8;
            if (s[1]) m_bo = (m_bo + 1) % 4;
            if (s[3] && !s[2]) begin
                if (m_cnt == 8) m_ovr = 1; else m_cnt++;
            end else if (s[2] && !s[3]) begin
                if (m_cnt == 0) m_und = 1; else m_cnt--;
            end
        end
    endtask

    function automatic st_t predict();
        st_t e;
        e.wr  = 3'(m_wr);
        e.rd  = 3'(m_rd);
        e.cnt = 4'(m_cnt);
        e.bo  = 2'(m_bo);
        case (m_bo)
            0:       e.blane = 4'b1000;
            1:       e.blane = 4'b0100;
            2:       e.blane = 4'b0010;
            default: e.blane = 4'b0001;
        endcase
        e.boeq3 = (m_bo == 3);
        e.full  = (m_cnt == 8);
        e.empty = (m_cnt == 0);
        e.ovr   = m_ovr;
        e.und   = m_und;
        return e;
    endfunction

    function automatic st_t observed();
        return {WRPTR, RDPTR, LWCOUNT, BO, BLANE, BOEQ3, FIFOFULL, FIFOEMPTY,
                OVERRUN, UNDERRUN};
    endfunction

    // One clock with the given strobes; prediction enters the scoreboard.
    task automatic drive(input logic [5:0] s);
        {INCNI, INCNO, INCFIFO, DECFIFO, INCBO, FLUSH} = s;
        model_step(s);
        exp_q.push_back(predict());
        @(posedge CPUCLK);
        #1;
        {INCNI, INCNO, INCFIFO, DECFIFO, INCBO, FLUSH} = S_ID;
    endtask

    task automatic test_reset();
        st_t e, o;
        RESET_ = 1'b0;
        repeat (2) @(posedge CPUCLK);
        #1;
        model_clear();
        exp_q.push_back(predict());
        e = exp_q.pop_front(); o = observed(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", o, e);
        end
        RESET_ = 1'b1;
        @(posedge CPUCLK); #1;
    endtask

    task automatic test_fill();
        st_t e, o;
        for (int i = 0; i < 8; i++) begin
            drive(S_IN);
            e = exp_q.pop_front(); o = observed(); checks++;
            if (o !== e || LWCOUNT !== 4'(i + 1) || FIFOFULL !== (i == 7)) begin
                failures++;
                $display("FAIL fill[%0d] got=%h exp=%h", i, o, e);
            end
            drive(S_ID);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_overrun();
        st_t e, o;
        logic [5:0] seq [3] = '{S_IN, S_DE, S_FL | S_IN | S_NI | S_BO};
        for (int i = 0; i < 3; i++) begin
            drive(seq[i]);
            e = exp_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL overrun[%0d] got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_underrun();
        st_t e, o;
        logic [5:0] seq [11] = '{S_DE, S_IN | S_DE, S_IN, S_IN, S_IN, S_IN,
                                  S_IN | S_DE, S_IN, S_IN, S_IN, S_IN};
        for (int i = 0; i < 11; i++) begin
            drive(seq[i]);
            e = exp_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL underrun[%0d] got=%h exp=%h", i, o, e);
            end
        end
        drive(S_IN | S_DE);
        e = exp_q.pop_front(); o = observed(); checks++;
        if (o !== e || OVERRUN !== 1'b0 || UNDERRUN !== 1'b1) begin
            failures++;
            $display("FAIL both_at_full got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_pointers();
        st_t e, o;
        drive(S_FL);
        void'(exp_q.pop_front());
        for (int i = 0; i < 19; i++) begin
            drive(i < 10 ? S_NI : S_NO);
            e = exp_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ptr[%0d] got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (RDPTR !== 3'd1 || WRPTR !== 3'd2) begin
            failures++;
            $display("FAIL ptr_final got=%0d/%0d exp=2/1", WRPTR, RDPTR);
        end
    endtask

    task automatic test_bo();
        st_t e, o;
        logic [3:0] lanes [6] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            drive(S_BO);
            e = exp_q.pop_front(); o = observed(); checks++;
            if (o !== e || BLANE !== lanes[i]) begin
                failures++;
                $display("FAIL bo[%0d] got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        st_t e, o;
        for (int i = 0; i < 60; i++) begin
            drive(6'($urandom_range(0, 31)) << 1);
            e = exp_q.pop_front(); o = observed(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_async_reset();
        st_t e, o;
        drive(S_FL);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(i < 2 ? (S_IN | S_BO) : S_IN);
            void'(exp_q.pop_front());
        end
        checks++;
        if (LWCOUNT !== 4'd5 || BO !== 2'd2) begin
            failures++;
            $display("FAIL preload got=%0d/%0d exp=5/2", LWCOUNT, BO);
        end
        #3 RESET_ = 1'b0;
        #1;
        model_clear();
        exp_q.push_back(predict());
        e = exp_q.pop_front(); o = observed(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", o, e);
        end
        #2 RESET_ = 1'b1;
        drive(S_IN);
        e = exp_q.pop_front(); o = observed(); checks++;
        if (o !== e || LWCOUNT !== 4'd1) begin
            failures++;
            $display("FAIL post_reset got=%h exp=%h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overrun();
        test_underrun();
        test_pointers();
        test_bo();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
